hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - hazard/stall controller for a 5-stage MIPS pipeline
//
// Purpose:
//   Decides each cycle whether the instruction in D must wait.
//   A data stall happens when a source operand is needed (Tuse) before the
//   producer in E or M can supply it (Tnew).
//   An MD stall holds HI/LO instructions in D while the multi-cycle mult/div
//   unit is busy.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   D_Instr/E_Instr/M_Instr  instruction words currently in D, E and M
//   stall               hazard stall this cycle (combinational)
//   F_WrEn, FD_WrEn     PC and F/D enables, both ~stall
//   DE_flush            bubble into D/E, equals stall
//   DE_WrEn             D/E enable, always 1
//   md_busy             mult/div busy counter nonzero
//   stall_cnt, md_stall_cnt  cycle counters (only with STALL_PERF_CNT_EN)
//
// Optional feature macro: STALL_PERF_CNT_EN
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D_Instr,
  input  logic [31:0] E_Instr,
  input  logic [31:0] M_Instr,
  output logic        stall,
  output logic        F_WrEn,
  output logic        FD_WrEn,
  output logic        DE_flush,
  output logic        DE_WrEn,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt,
`endif
  output logic        md_busy
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       rs_rd;     // rs is a source operand
    logic       rt_rd;     // rt is a source operand
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [1:0] tnew_e;    // Tnew while in E
    logic [1:0] tnew_m;    // Tnew while in M
    logic       md_start;  // mult/multu/div/divu
    logic       md_mult;   // mult/multu
    logic       md_use;    // any instruction touching the mult/div unit
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d    = '0;
    d.rs = ins[25:21];
    d.rt = ins[20:16];
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h21, 6'h23: begin // addu, subu
            d.dst = ins[15:11]; d.tnew_e = 2'd1;
            d.rs_rd = 1'b1; d.tuse_rs = 2'd1;
            d.rt_rd = 1'b1; d.tuse_rt = 2'd1;
          end
          6'h08: begin // jr
            d.rs_rd = 1'b1; d.tuse_rs = 2'd0;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin // mult, multu, div, divu
            d.rs_rd = 1'b1; d.tuse_rs = 2'd1;
            d.rt_rd = 1'b1; d.tuse_rt = 2'd1;
            d.md_start = 1'b1; d.md_use = 1'b1;
            d.md_mult  = ~ins[1];
          end
          6'h10, 6'h12: begin // mfhi, mflo
            d.dst = ins[15:11]; d.tnew_e = 2'd1; d.md_use = 1'b1;
          end
          6'h11, 6'h13: begin // mthi, mtlo
            d.rs_rd = 1'b1; d.tuse_rs = 2'd1; d.md_use = 1'b1;
          end
          default: d = '0;
        endcase
      end
      6'h0D: begin // ori
        d.rs_rd = 1'b1; d.tuse_rs = 2'd1; d.dst = ins[20:16]; d.tnew_e = 2'd1;
      end
      6'h23: begin // lw
        d.rs_rd = 1'b1; d.tuse_rs = 2'd1; d.dst = ins[20:16];
        d.tnew_e = 2'd2; d.tnew_m = 2'd1;
      end
      6'h2B: begin // sw
        d.rs_rd = 1'b1; d.tuse_rs = 2'd1; d.rt_rd = 1'b1; d.tuse_rt = 2'd2;
      end
      6'h04: begin // beq
        d.rs_rd = 1'b1; d.tuse_rs = 2'd0; d.rt_rd = 1'b1; d.tuse_rt = 2'd0;
      end
      6'h0F: begin // lui
        d.dst = ins[20:16]; d.tnew_e = 2'd1;
      end
      6'h03: begin // jal, result available immediately (Tnew 0)
        d.dst = 5'd31;
      end
      default: d = '0; // j and unknown encodings read and write nothing
    endcase
    return d;
  endfunction

  function automatic logic hazard(input logic rd, input logic [4:0] src,
                                  input logic [1:0] tuse, input logic [4:0] dst,
                                  input logic [1:0] tnew);
    return rd && (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

  dec_t d_dec, e_dec, m_dec;
  logic data_stall, md_stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign d_dec = decode(D_Instr);
  assign e_dec = decode(E_Instr);
  assign m_dec = decode(M_Instr);

  always_comb begin
    data_stall = hazard(d_dec.rs_rd, d_dec.rs, d_dec.tuse_rs, e_dec.dst, e_dec.tnew_e)
               | hazard(d_dec.rt_rd, d_dec.rt, d_dec.tuse_rt, e_dec.dst, e_dec.tnew_e)
               | hazard(d_dec.rs_rd, d_dec.rs, d_dec.tuse_rs, m_dec.dst, m_dec.tnew_m)
               | hazard(d_dec.rt_rd, d_dec.rt, d_dec.tuse_rt, m_dec.dst, m_dec.tnew_m);
  end

  assign md_busy  = (cnt_q != '0);
  assign md_stall = d_dec.md_use & (md_busy | e_dec.md_start);
  assign stall    = data_stall | md_stall;
  assign F_WrEn   = ~stall;
  assign FD_WrEn  = ~stall;
  assign DE_flush = stall;
  assign DE_WrEn  = 1'b1;

  // A new mult/div in E always reloads, even if a count is still running.
  always_comb begin
    cnt_d = cnt_q;
    if (e_dec.md_start && e_dec.md_mult) cnt_d = CNT_W'(MULT_CYCLES);
    else if (e_dec.md_start)             cnt_d = CNT_W'(DIV_CYCLES);
    else if (cnt_q != '0)                cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, md_stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      if (stall)    stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (md_stall) md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

  // Decoder fields and instruction bits not needed for a given stage.
  logic unused_bits;
  assign unused_bits = ^{d_dec, e_dec, m_dec, D_Instr[10:6], E_Instr[10:6], M_Instr[10:6]};

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] D_Instr, E_Instr, M_Instr;
  logic        stall, F_WrEn, FD_WrEn, DE_flush, DE_WrEn, md_busy;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .D_Instr(D_Instr), .E_Instr(E_Instr), .M_Instr(M_Instr),
    .stall(stall), .F_WrEn(F_WrEn), .FD_WrEn(FD_WrEn),
    .DE_flush(DE_flush), .DE_WrEn(DE_WrEn),
`ifdef STALL_PERF_CNT_EN
    .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt),
`endif
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d, e, m;
    logic        stall;
    string       name;
  } vec_t;

  typedef struct {
    logic  stall;
    logic  busy;
    string name;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] rt_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
    logic [31:0] r;
    r = {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    return r;
  endfunction

  function automatic logic [31:0] it_ins(input logic [5:0] op, input int rs, input int rt);
    logic [31:0] r;
    r = {op, rs[4:0], rt[4:0], 16'h0004};
    return r;
  endfunction

  task automatic add(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                     input logic s, input string nm);
    vec_t v;
    v.d = d; v.e = e; v.m = m; v.stall = s; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                       input logic s, input logic b, input string nm);
    exp_t x;
    D_Instr = d; E_Instr = e; M_Instr = m;
    x.stall = s; x.busy = b; x.name = nm;
    sbq.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      x = sbq.pop_front();
      if (stall !== x.stall || F_WrEn !== ~x.stall || FD_WrEn !== ~x.stall ||
          DE_flush !== x.stall || DE_WrEn !== 1'b1 || md_busy !== x.busy) begin
        miscompares++;
        $display("FAIL %s: got stall=%b F_WrEn=%b FD_WrEn=%b DE_flush=%b DE_WrEn=%b md_busy=%b, want stall=%b md_busy=%b",
                 x.name, stall, F_WrEn, FD_WrEn, DE_flush, DE_WrEn, md_busy, x.stall, x.busy);
      end
    end
  endtask

  // One clock cycle: drive after the rising edge, compare on the falling edge.
  task automatic cycle(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                       input logic s, input logic b, input string nm);
    drive(d, e, m, s, b, nm);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] lw8, lw0, addu8, addu_988, addu_900, beq8, sw8rt, sw8rs, jal_i, jr31;
  logic [31:0] ori8, addu_918, lui5, mthi5, mfhi4, beq44, mult89, mult12, div12, mflo3;
  logic [31:0] lw9, unk, j_i, addu_931, beq31;

  initial begin
    lw8      = it_ins(6'h23, 0, 8);
    lw0      = it_ins(6'h23, 0, 0);
    lw9      = it_ins(6'h23, 0, 9);
    addu8    = rt_ins(1, 2, 8, 6'h21);
    addu_988 = rt_ins(8, 8, 9, 6'h21);
    addu_900 = rt_ins(0, 0, 9, 6'h21);
    addu_918 = rt_ins(1, 8, 9, 6'h21);
    addu_931 = rt_ins(31, 0, 9, 6'h21);
    beq8     = it_ins(6'h04, 8, 0);
    beq31    = it_ins(6'h04, 31, 0);
    beq44    = it_ins(6'h04, 4, 4);
    sw8rt    = it_ins(6'h2B, 1, 8);
    sw8rs    = it_ins(6'h2B, 8, 1);
    jal_i    = {6'h03, 26'h0000100};
    j_i      = {6'h02, 26'h0000100};
    jr31     = rt_ins(31, 0, 0, 6'h08);
    ori8     = it_ins(6'h0D, 1, 8);
    lui5     = it_ins(6'h0F, 0, 5);
    mthi5    = rt_ins(5, 0, 0, 6'h11);
    mfhi4    = rt_ins(0, 0, 4, 6'h10);
    mult89   = rt_ins(8, 9, 0, 6'h18);
    mult12   = rt_ins(1, 2, 0, 6'h18);
    div12    = rt_ins(1, 2, 0, 6'h1A);
    mflo3    = rt_ins(0, 0, 3, 6'h12);
    unk      = {6'h3F, 5'd8, 5'd8, 16'h0};

    add(addu_988, lw8,   NOP,   1'b1, "lw-use E");
    add(addu_988, NOP,   lw8,   1'b0, "lw-use M fwd");
    add(beq8,     addu8, NOP,   1'b1, "beq after addu");
    add(sw8rt,    addu8, NOP,   1'b0, "sw rt after addu");
    add(jr31,     jal_i, NOP,   1'b0, "jr after jal");
    add(addu_900, lw0,   NOP,   1'b0, "reg0 ignored");
    add(beq8,     NOP,   lw8,   1'b1, "beq lw in M");
    add(beq8,     NOP,   addu8, 1'b0, "beq addu in M");
    add(sw8rt,    lw8,   NOP,   1'b0, "sw rt after lw");
    add(sw8rs,    lw8,   NOP,   1'b1, "sw rs after lw");
    add(addu_918, ori8,  NOP,   1'b0, "addu after ori");
    add(mthi5,    lui5,  NOP,   1'b0, "mthi after lui");
    add(beq44,    mfhi4, NOP,   1'b1, "beq after mfhi");
    add(mult89,   lw8,   NOP,   1'b1, "mult after lw");
    add(mult89,   NOP,   lw9,   1'b0, "mult lw9 in M");
    add(unk,      lw8,   NOP,   1'b0, "unknown op");
    add(j_i,      lw8,   NOP,   1'b0, "j reads nothing");
    add(addu_931, jal_i, NOP,   1'b0, "addu after jal");
    add(beq31,    NOP,   jal_i, 1'b0, "beq jal in M");

    reset = 1'b1;
    D_Instr = NOP; E_Instr = NOP; M_Instr = NOP;
    drive(NOP, NOP, NOP, 1'b0, 1'b0, "reset state");
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i]) cycle(tbl[i].d, tbl[i].e, tbl[i].m, tbl[i].stall, 1'b0, tbl[i].name);

    // mult then waiting mflo
    cycle(mflo3, mult12, NOP, 1'b1, 1'b0, "mult t");
    for (int k = 1; k <= 5; k++) cycle(mflo3, NOP, NOP, 1'b1, 1'b1, $sformatf("mult t+%0d", k));
    cycle(mflo3, NOP, NOP, 1'b0, 1'b0, "mult t+6");

    // div then waiting mflo
    cycle(mflo3, div12, NOP, 1'b1, 1'b0, "div t");
    for (int k = 1; k <= 10; k++) cycle(mflo3, NOP, NOP, 1'b1, 1'b1, $sformatf("div t+%0d", k));
    cycle(mflo3, NOP, NOP, 1'b0, 1'b0, "div t+11");

    // div in E while mult count still running reloads the counter
    cycle(NOP, mult12, NOP, 1'b0, 1'b0, "reload mult");
    cycle(NOP, NOP,    NOP, 1'b0, 1'b1, "reload t+1");
    cycle(NOP, div12,  NOP, 1'b0, 1'b1, "reload div");
    for (int k = 1; k <= 10; k++) cycle(NOP, NOP, NOP, 1'b0, 1'b1, $sformatf("reload busy %0d", k));
    cycle(NOP, NOP, NOP, 1'b0, 1'b0, "reload done");

    // asynchronous reset in the middle of a div count
    cycle(NOP,   div12, NOP, 1'b0, 1'b0, "rst div t");
    cycle(mflo3, NOP,   NOP, 1'b1, 1'b1, "rst div t+1");
    drive(mflo3, NOP, NOP, 1'b0, 1'b0, "async reset");
    #2;
    reset = 1'b1;
    #1;
    check_out();
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(mflo3, NOP, NOP, 1'b0, 1'b0, "after reset");

`ifdef STALL_PERF_CNT_EN
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(addu_988, lw8, NOP, 1'b1, 1'b0, "perf lw-use");
    cycle(addu_988, NOP, lw8, 1'b0, 1'b0, "perf lw-use M");
    cycle(mflo3, mult12, NOP, 1'b1, 1'b0, "perf mult t");
    for (int k = 1; k <= 5; k++) cycle(mflo3, NOP, NOP, 1'b1, 1'b1, "perf mult wait");
    cycle(NOP, NOP, NOP, 1'b0, 1'b0, "perf idle");
    vectors++;
    if (stall_cnt !== 32'd7) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d, want 7", stall_cnt);
    end
    vectors++;
    if (md_stall_cnt !== 32'd6) begin
      miscompares++;
      $display("FAIL md_stall_cnt: got %0d, want 6", md_stall_cnt);
    end
`endif

    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d expected entries never compared", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
